// File: rtl/mc_prog_delay_pkg.sv
// Shared defaults and helpers for the programmable multi-channel delay line.
// Optional build macro: DLY_DATA_RST_EN (adds reset to the data stages).
package mc_prog_delay_pkg;

  localparam int unsigned D_WIDTH       = 64;
  localparam int unsigned CH_DEF        = 16;
  localparam int unsigned MAX_DEPTH_DEF = 32;
  localparam int unsigned DEF_DEPTH_DEF = 21;
  localparam int unsigned DW_DEF        = 6;
  localparam int unsigned LANE_STRIDE   = D_WIDTH;

  // A depth is usable when it selects an existing stage (1..max_d).
  function automatic logic depth_legal(input int unsigned d, input int unsigned max_d);
    return (d != 0) && (d <= max_d);
  endfunction

  function automatic int unsigned lane_lsb(input int unsigned k, input int unsigned w);
    return k * w;
  endfunction

endpackage

// File: rtl/mc_dly_lane.sv
// One W-bit lane: MAX_DEPTH-stage shift register with stall and a tap mux.
// Data stages reset only when DLY_DATA_RST_EN is defined.
module mc_dly_lane
  import mc_prog_delay_pkg::*;
#(
  parameter int unsigned W         = D_WIDTH,
  parameter int unsigned MAX_DEPTH = MAX_DEPTH_DEF,
  parameter int unsigned DW        = DW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [W-1:0]  in_data,
  input  logic [DW-1:0] tap_sel,
  output logic [W-1:0]  out_data
);

  logic [W-1:0] s_q [MAX_DEPTH];

`ifdef DLY_DATA_RST_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(MAX_DEPTH); i++) s_q[i] <= '0;
    end else if (en) begin
      s_q[0] <= in_data;
      for (int i = 1; i < int'(MAX_DEPTH); i++) s_q[i] <= s_q[i-1];
    end
  end
`else
  logic unused_rst;
  assign unused_rst = rst;

  always_ff @(posedge clk) begin
    if (en) begin
      s_q[0] <= in_data;
      for (int i = 1; i < int'(MAX_DEPTH); i++) s_q[i] <= s_q[i-1];
    end
  end
`endif

  // tap_sel is 1-based; stage s[k] lives at s_q[k-1]
  always_comb begin
    out_data = '0;
    for (int unsigned i = 0; i < MAX_DEPTH; i++) begin
      if (tap_sel == DW'(i + 1)) out_data = s_q[i];
    end
  end

endmodule

// File: rtl/mc_prog_delay.sv
// Programmable-depth multi-lane delay line with stall, flush and shared valid pipe.
// Optional build macro: DLY_DATA_RST_EN (data stages reset to zero).
module mc_prog_delay
  import mc_prog_delay_pkg::*;
#(
  parameter int unsigned CH        = CH_DEF,
  parameter int unsigned W         = D_WIDTH,
  parameter int unsigned MAX_DEPTH = MAX_DEPTH_DEF,
  parameter int unsigned DEF_DEPTH = DEF_DEPTH_DEF,
  parameter int unsigned DW        = DW_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            flush,
  input  logic            cfg_load,
  input  logic [DW-1:0]   cfg_depth,
  input  logic            in_valid,
  input  logic [CH*W-1:0] in_data,
  output logic            out_valid,
  output logic [CH*W-1:0] out_data,
  output logic [DW-1:0]   cur_depth,
  output logic            cfg_err,
  output logic            busy
);

  logic [MAX_DEPTH-1:0] valid_q, valid_d;
  logic [DW-1:0]        depth_q, depth_d;
  logic                 err_q, err_d;
  logic                 clr_c;

  // Config load always implies a flush so no beat leaves at a mixed latency.
  always_comb begin
    depth_d = depth_q;
    err_d   = err_q;
    valid_d = valid_q;
    clr_c   = flush | cfg_load;
    if (cfg_load) begin
      if (depth_legal(32'(cfg_depth), MAX_DEPTH)) begin
        depth_d = cfg_depth;
      end else begin
        depth_d = DW'(MAX_DEPTH);
        err_d   = 1'b1;
      end
    end
    if (clr_c) begin
      valid_d = '0;
    end else if (en) begin
      valid_d = (valid_q << 1) | MAX_DEPTH'(in_valid);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      depth_q <= DW'(DEF_DEPTH);
      err_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      depth_q <= depth_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    out_valid = 1'b0;
    for (int unsigned i = 0; i < MAX_DEPTH; i++) begin
      if (depth_q == DW'(i + 1)) out_valid = valid_q[i];
    end
  end

  assign cur_depth = depth_q;
  assign cfg_err   = err_q;
  assign busy      = |valid_q;

  for (genvar k = 0; k < int'(CH); k++) begin : g_lane
    mc_dly_lane #(
      .W         (W),
      .MAX_DEPTH (MAX_DEPTH),
      .DW        (DW)
    ) u_lane (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .in_data  (in_data[lane_lsb(k, W) +: W]),
      .tap_sel  (depth_q),
      .out_data (out_data[lane_lsb(k, W) +: W])
    );
  end

endmodule

// File: tb/tb_mc_prog_delay.sv
// Self-checking bench for mc_prog_delay against a beat-age reference model.
module tb_mc_prog_delay;

  localparam int unsigned CH        = 16;
  localparam int unsigned W         = 64;
  localparam int unsigned MAX_DEPTH = 32;
  localparam int unsigned DEF_DEPTH = 21;
  localparam int unsigned DW        = 6;
  localparam int unsigned DBITS     = CH * W;

  logic             clk = 1'b0;
  logic             rst, en, flush, cfg_load, in_valid;
  logic [DW-1:0]    cfg_depth;
  logic [DBITS-1:0] in_data;
  logic             out_valid, cfg_err, busy;
  logic [DBITS-1:0] out_data;
  logic [DW-1:0]    cur_depth;

  mc_prog_delay #(
    .CH(CH), .W(W), .MAX_DEPTH(MAX_DEPTH), .DEF_DEPTH(DEF_DEPTH), .DW(DW)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .flush(flush), .cfg_load(cfg_load),
    .cfg_depth(cfg_depth), .in_valid(in_valid), .in_data(in_data),
    .out_valid(out_valid), .out_data(out_data), .cur_depth(cur_depth),
    .cfg_err(cfg_err), .busy(busy)
  );

  always #5 clk = ~clk;

  // Model: each live beat carries its age in enabled edges; it is at the tap when age == depth.
  typedef struct {
    int unsigned      age;
    logic [DBITS-1:0] data;
  } beat_t;

  beat_t       mq[$];
  int unsigned m_depth;
  logic        m_err;
  int          total = 0;
  int          bad   = 0;

  function automatic logic [DBITS-1:0] rnd_data();
    logic [DBITS-1:0] r;
    for (int k = 0; k < int'(DBITS / 32); k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [DBITS-1:0] pat(input int unsigned b);
    logic [DBITS-1:0] r;
    r[0 +: W] = W'(b);
    for (int k = 1; k < int'(CH); k++) r[k*W +: W] = ~W'(b);
    return r;
  endfunction

  task automatic check();
    logic             exp_v;
    logic [DBITS-1:0] exp_d;
    logic             exp_b;
    int               ln;
    exp_v = 1'b0;
    exp_d = '0;
    foreach (mq[i]) if (mq[i].age == m_depth) begin exp_v = 1'b1; exp_d = mq[i].data; end
    exp_b = (mq.size() != 0);
    total++;
    assert (out_valid === exp_v) else begin
      bad++; $error("FAIL out_valid got=%0b exp=%0b t=%0t", out_valid, exp_v, $time);
    end
    total++;
    assert (busy === exp_b) else begin
      bad++; $error("FAIL busy got=%0b exp=%0b t=%0t", busy, exp_b, $time);
    end
    total++;
    assert (cur_depth === DW'(m_depth)) else begin
      bad++; $error("FAIL cur_depth got=%0d exp=%0d t=%0t", cur_depth, m_depth, $time);
    end
    total++;
    assert (cfg_err === m_err) else begin
      bad++; $error("FAIL cfg_err got=%0b exp=%0b t=%0t", cfg_err, m_err, $time);
    end
    if (exp_v) begin
      total++;
      assert (out_data === exp_d) else begin
        ln = 0;
        for (int k = 0; k < int'(CH); k++) if (out_data[k*W +: W] !== exp_d[k*W +: W]) ln = k;
        bad++;
        $error("FAIL out_data lane=%0d got=%h exp=%h t=%0t", ln, out_data[ln*W +: W],
               exp_d[ln*W +: W], $time);
      end
    end
  endtask

  task automatic tick(input logic e, input logic f, input logic cl, input int unsigned cd,
                      input logic iv, input logic [DBITS-1:0] id);
    en = e; flush = f; cfg_load = cl; cfg_depth = DW'(cd); in_valid = iv; in_data = id;
    @(posedge clk);
    if (cl) begin
      if (cd >= 1 && cd <= MAX_DEPTH) m_depth = cd;
      else begin m_depth = MAX_DEPTH; m_err = 1'b1; end
    end
    if (f || cl) begin
      mq.delete();
    end else if (e) begin
      foreach (mq[i]) mq[i].age++;
      while (mq.size() > 0 && mq[0].age > MAX_DEPTH) void'(mq.pop_front());
      if (iv) mq.push_back('{age: 1, data: id});
    end
    #1;
    check();
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    for (int i = 0; i < n; i++) begin
      en = $urandom_range(0, 1); in_valid = $urandom_range(0, 1); in_data = rnd_data();
      flush = 1'b0; cfg_load = 1'b0;
      @(posedge clk);
      mq.delete(); m_depth = DEF_DEPTH; m_err = 1'b0;
      #1;
      check();
    end
    rst = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b1, 1'b0, 1'b0, 0, 1'b0, rnd_data());
  endtask

  task automatic send(input logic [DBITS-1:0] d);
    tick(1'b1, 1'b0, 1'b0, 0, 1'b1, d);
  endtask

  task automatic load(input int unsigned cd);
    tick(1'b1, 1'b0, 1'b1, cd, 1'b0, rnd_data());
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; en = 1'b0; flush = 1'b0; cfg_load = 1'b0; cfg_depth = '0;
    in_valid = 1'b0; in_data = '0;
    m_depth = DEF_DEPTH; m_err = 1'b0;

    // reset state and default 21-cycle latency
    do_reset(2);
`ifdef DLY_DATA_RST_EN
    total++;
    assert (out_data === '0) else begin
      bad++; $error("FAIL data_rst got_lane0=%h exp=0", out_data[0 +: W]);
    end
`endif
    for (int b = 1; b <= 5; b++) send(pat(b));
    idle(24);

    // reprogram to 3, stream, then shrink to 1 with beats in flight
    load(3);
    for (int i = 0; i < 10; i++) send(rnd_data());
    idle(5);
    for (int i = 0; i < 3; i++) send(rnd_data());
    tick(1'b1, 1'b0, 1'b1, 1, 1'b1, rnd_data());
    for (int i = 0; i < 4; i++) send(rnd_data());
    idle(3);

    // stall mid-flight at depth 4
    load(4);
    send(pat(32'hA));
    idle(1);
    for (int i = 0; i < 5; i++) tick(1'b0, 1'b0, 1'b0, 0, 1'b1, rnd_data());
    idle(5);

    // illegal configs, sticky error, reset clears it
    load(0);
    load(40);
    load(7);
    send(rnd_data());
    idle(8);
    do_reset(1);

    // flush collisions
    load(4);
    send(rnd_data());
    send(rnd_data());
    tick(1'b0, 1'b1, 1'b0, 0, 1'b1, rnd_data());
    idle(6);
    send(rnd_data());
    send(rnd_data());
    tick(1'b1, 1'b1, 1'b1, 6, 1'b1, rnd_data());
    for (int i = 0; i < 3; i++) send(rnd_data());
    idle(8);
    load(MAX_DEPTH);
    for (int i = 0; i < 3; i++) send(rnd_data());
    idle(MAX_DEPTH);

    // randomized traffic with occasional stalls, flushes and reloads
    for (int i = 0; i < 600; i++) begin
      tick(($urandom_range(0, 9) < 8), ($urandom_range(0, 49) == 0),
           ($urandom_range(0, 59) == 0), $urandom_range(0, 40),
           $urandom_range(0, 1), rnd_data());
    end

    // reset mid-operation: first beat after sees the default depth
    load(5);
    for (int i = 0; i < 3; i++) send(rnd_data());
    do_reset(1);
    send(rnd_data());
    idle(DEF_DEPTH + 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
